// File: rtl/ram_pkg.sv
// Shared definitions for the RAM responder: SPARC op3 codes, access sizes,
// FSM states and the opcode decoder.
package ram_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD,
        DWORD
    } access_size_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        ACCESS2,
        FAULT
    } state_t;

    typedef struct packed {
        logic         legal;
        logic         is_store;
        logic         is_signed;
        access_size_t size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '{legal: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: WORD};
        case (op)
            OP_LD:   info.size = WORD;
            OP_LDUB: info.size = BYTE;
            OP_LDUH: info.size = HALF;
            OP_LDSB: begin info.size = BYTE; info.is_signed = 1'b1; end
            OP_LDSH: begin info.size = HALF; info.is_signed = 1'b1; end
            OP_LDD:  info.size = DWORD;
            OP_ST:   begin info.size = WORD;  info.is_store = 1'b1; end
            OP_STB:  begin info.size = BYTE;  info.is_store = 1'b1; end
            OP_STH:  begin info.size = HALF;  info.is_store = 1'b1; end
            OP_STD:  begin info.size = DWORD; info.is_store = 1'b1; end
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/ram_responder_byte_lane_aligner.sv
// Big-endian byte-lane steering between a 32-bit memory word and the CPU:
// extracts/extends load data and builds the store word plus lane write mask.
module byte_lane_aligner
    import ram_pkg::*;
(
    input  access_size_t size,
    input  logic         is_signed,
    input  logic [1:0]   addr_lo,
    input  logic [31:0]  mem_word,
    input  logic [31:0]  store_data,
    output logic [31:0]  load_data,
    output logic [31:0]  store_word,
    output logic [3:0]   lane_mask
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Mask bit k enables bits [8k+7:8k]; byte offset 0 lives in lane 3.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_val = mem_word[31:24];
            2'd1:    byte_val = mem_word[23:16];
            2'd2:    byte_val = mem_word[15:8];
            default: byte_val = mem_word[7:0];
        endcase
        half_val = addr_lo[1] ? mem_word[15:0] : mem_word[31:16];

        load_data  = mem_word;
        store_word = store_data;
        lane_mask  = 4'b1111;
        case (size)
            BYTE: begin
                load_data  = is_signed ? {{24{byte_val[7]}}, byte_val} : {24'd0, byte_val};
                store_word = {4{store_data[7:0]}};
                lane_mask  = 4'b1000 >> addr_lo;
            end
            HALF: begin
                load_data  = is_signed ? {{16{half_val[15]}}, half_val} : {16'd0, half_val};
                store_word = {2{store_data[15:0]}};
                lane_mask  = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the CPU load/store handshake: decodes op3, waits
// WAIT_STATES cycles, accesses the byte array and answers with MFC or Trap.
module ram_responder
    import ram_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [31:0] DataIn_hi,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        Beat,
    output logic        Trap,
    output logic        Busy
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [31:0]   data_hi_q;
    access_size_t  size_q;
    logic          signed_q;
    logic          store_q;

    op_info_t      req_info;
    logic          aligned;
    logic          in_range;
    logic          req_ok;

    logic [AW-1:0] cur_addr;
    logic [AW-1:0] word_base;
    logic [AW-1:0] lane_addr [4];
    logic [31:0]   mem_word;
    logic [31:0]   cur_data;
    access_size_t  lane_size;
    logic [31:0]   load_data;
    logic [31:0]   store_word;
    logic [3:0]    lane_mask;
    logic          do_write;

    // Request qualification happens on the live inputs at the accepting edge.
    always_comb begin
        req_info = decode_op(RAM_OpCode);
        case (req_info.size)
            HALF:    aligned = (Address[0] == 1'b0);
            WORD:    aligned = (Address[1:0] == 2'b00);
            DWORD:   aligned = (Address[2:0] == 3'b000);
            default: aligned = 1'b1;
        endcase
        if (req_info.size == DWORD)
            in_range = ({1'b0, Address} + 33'd7) < 33'(DEPTH);
        else
            in_range = {1'b0, Address} < 33'(DEPTH);
        req_ok = req_info.legal && aligned && in_range;
    end

    // The second beat of ldd/std is a plain word access four bytes higher.
    always_comb begin
        cur_addr  = (state == ACCESS2) ? addr_q + AW'(4) : addr_q;
        cur_data  = (state == ACCESS2) ? data_hi_q : data_q;
        lane_size = (size_q == DWORD) ? WORD : size_q;
        word_base = {cur_addr[AW-1:2], 2'b00};
        for (int j = 0; j < 4; j++)
            lane_addr[j] = word_base + AW'(j);
        mem_word = {mem[lane_addr[0]], mem[lane_addr[1]], mem[lane_addr[2]], mem[lane_addr[3]]};
        do_write = store_q && ((state == ACCESS) || (state == ACCESS2));
    end

    byte_lane_aligner u_aligner (
        .size       (lane_size),
        .is_signed  (signed_q),
        .addr_lo    (cur_addr[1:0]),
        .mem_word   (mem_word),
        .store_data (cur_data),
        .load_data  (load_data),
        .store_word (store_word),
        .lane_mask  (lane_mask)
    );

    // Memory is never reset; reset forces IDLE so an aborted store cannot write.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++)
                if (lane_mask[k])
                    mem[lane_addr[3-k]] <= store_word[8*k +: 8];
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            data_hi_q <= '0;
            size_q    <= WORD;
            signed_q  <= 1'b0;
            store_q   <= 1'b0;
            DataOut   <= '0;
            MFC       <= 1'b0;
            Beat      <= 1'b0;
            Trap      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            MFC  <= 1'b0;
            Beat <= 1'b0;
            Trap <= 1'b0;
            case (state)
                IDLE: begin
                    if (RAM_enable) begin
                        addr_q    <= Address[AW-1:0];
                        data_q    <= DataIn;
                        data_hi_q <= DataIn_hi;
                        size_q    <= req_info.size;
                        signed_q  <= req_info.is_signed;
                        store_q   <= req_info.is_store;
                        wait_cnt  <= '0;
                        Busy      <= 1'b1;
                        if (!req_ok)
                            state <= FAULT;
                        else if (WAIT_STATES == 0)
                            state <= ACCESS;
                        else
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(WAIT_STATES - 1))
                        state <= ACCESS;
                    else
                        wait_cnt <= wait_cnt + 4'd1;
                end
                ACCESS: begin
                    MFC <= 1'b1;
                    if (!store_q)
                        DataOut <= load_data;
                    if (size_q == DWORD) begin
                        state <= ACCESS2;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                ACCESS2: begin
                    MFC  <= 1'b1;
                    Beat <= 1'b1;
                    if (!store_q)
                        DataOut <= load_data;
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                FAULT: begin
                    Trap  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a schedule-based reference model compared
// every cycle, plus hand-computed expectations for the key transactions.
module tb_ram_responder;

    localparam int DEPTH = 512;
    localparam int WS    = 2;
    localparam int LAT   = WS + 1;

    logic        Clk = 1'b0;
    logic        RESET = 1'b0;
    logic        RAM_enable = 1'b0;
    logic [5:0]  RAM_OpCode = '0;
    logic [31:0] Address = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataIn_hi = '0;
    logic [31:0] DataOut;
    logic        MFC;
    logic        Beat;
    logic        Trap;
    logic        Busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    ram_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .Clk        (Clk),
        .RESET      (RESET),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .Address    (Address),
        .DataIn     (DataIn),
        .DataIn_hi  (DataIn_hi),
        .DataOut    (DataOut),
        .MFC        (MFC),
        .Beat       (Beat),
        .Trap       (Trap),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    endtask

    // Reference model: byte memory plus a per-request schedule of output events.
    logic [7:0]  ref_mem [DEPTH];
    bit          m_active = 0;
    bit          m_fault = 0;
    bit          m_store = 0;
    bit          m_signed = 0;
    int          m_nbytes = 0;
    int          m_acc = 0;
    int          m_end = 0;
    int          m_addr = 0;
    logic [31:0] m_din = '0;
    logic [31:0] m_dhi = '0;
    int          edge_cnt = 0;
    bit          exp_MFC = 0;
    bit          exp_Beat = 0;
    bit          exp_Trap = 0;
    bit          exp_Busy = 0;
    logic [31:0] exp_DataOut = '0;

    initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    function automatic void decodeRef(input logic [5:0] op, output bit legal, output int nbytes,
                                      output bit sgn, output bit store);
        legal = 1; sgn = 0; store = 0; nbytes = 4;
        case (op)
            6'b000000: nbytes = 4;
            6'b000001: nbytes = 1;
            6'b000010: nbytes = 2;
            6'b001001: begin nbytes = 1; sgn = 1; end
            6'b001010: begin nbytes = 2; sgn = 1; end
            6'b000011: nbytes = 8;
            6'b000100: begin nbytes = 4; store = 1; end
            6'b000101: begin nbytes = 1; store = 1; end
            6'b000110: begin nbytes = 2; store = 1; end
            6'b000111: begin nbytes = 8; store = 1; end
            default:   legal = 0;
        endcase
    endfunction

    always @(posedge Clk or posedge RESET) begin
        bit legal;
        int b, a, n;
        logic [31:0] v;
        if (RESET) begin
            m_active = 0;
            exp_MFC = 0; exp_Beat = 0; exp_Trap = 0; exp_Busy = 0; exp_DataOut = '0;
        end else begin
            edge_cnt++;
            if (!m_active && RAM_enable) begin
                decodeRef(RAM_OpCode, legal, m_nbytes, m_signed, m_store);
                m_active = 1;
                m_acc    = edge_cnt;
                m_addr   = int'(Address);
                m_din    = DataIn;
                m_dhi    = DataIn_hi;
                m_fault  = !legal || (Address % m_nbytes != 0)
                           || (longint'(Address) + longint'(m_nbytes) > longint'(DEPTH));
                m_end    = m_fault ? m_acc + 1 : m_acc + LAT + (m_nbytes == 8 ? 1 : 0);
            end
            exp_MFC = 0; exp_Beat = 0; exp_Trap = 0; exp_Busy = 0;
            if (m_active) begin
                if (m_fault) begin
                    exp_Trap = (edge_cnt == m_acc + 1);
                end else if (edge_cnt >= m_acc + LAT) begin
                    b = edge_cnt - (m_acc + LAT);
                    a = m_addr + 4 * b;
                    n = (m_nbytes > 4) ? 4 : m_nbytes;
                    exp_MFC  = 1;
                    exp_Beat = (b == 1);
                    if (m_store) begin
                        v = (b == 0) ? m_din : m_dhi;
                        for (int i = 0; i < n; i++)
                            ref_mem[a + i] = 8'(v >> (8 * (n - 1 - i)));
                    end else begin
                        v = '0;
                        for (int i = 0; i < n; i++)
                            v = (v << 8) | {24'd0, ref_mem[a + i]};
                        if (m_signed && n == 1 && v[7])  v = v | 32'hFFFFFF00;
                        if (m_signed && n == 2 && v[15]) v = v | 32'hFFFF0000;
                        exp_DataOut = v;
                    end
                end
                exp_Busy = (edge_cnt < m_end);
                if (edge_cnt == m_end) m_active = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            checkOutput("cmp_MFC", {31'd0, MFC}, {31'd0, exp_MFC});
            checkOutput("cmp_Beat", {31'd0, Beat}, {31'd0, exp_Beat});
            checkOutput("cmp_Trap", {31'd0, Trap}, {31'd0, exp_Trap});
            checkOutput("cmp_Busy", {31'd0, Busy}, {31'd0, exp_Busy});
            checkOutput("cmp_DataOut", DataOut, exp_DataOut);
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] din,
                                 input logic [31:0] dhi, input bit pulse_busy,
                                 output int lat, output int trap_lat, output int mfc_cnt,
                                 output logic [31:0] d0, output logic [31:0] d1);
        bit done;
        done = 0; lat = -1; trap_lat = -1; mfc_cnt = 0; d0 = '0; d1 = '0;
        @(negedge Clk);
        RAM_OpCode = op; Address = addr; DataIn = din; DataIn_hi = dhi; RAM_enable = 1'b1;
        @(posedge Clk);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge Clk);
            RAM_enable = pulse_busy && (cyc == 1);
            if (MFC) begin
                mfc_cnt++;
                if (!Beat) begin lat = cyc; d0 = DataOut; end
                else d1 = DataOut;
            end
            if (Trap) trap_lat = cyc;
            if (cyc > 0 && !Busy && !MFC && !Trap) done = 1;
        end
        if (!done) checkOutput("handshake_timeout", 32'd0, 32'd1);
    endtask

    int          lat, tlat, mcnt;
    logic [31:0] d0, d1;

    initial begin
        #2 RESET = 1'b1;
        @(negedge Clk); @(negedge Clk);
        RESET = 1'b0;
        checkOutput("reset_DataOut", DataOut, 32'h0);
        checkOutput("reset_MFC", {31'd0, MFC}, 32'h0);
        checkOutput("reset_Busy", {31'd0, Busy}, 32'h0);
        checkOutput("reset_Trap", {31'd0, Trap}, 32'h0);
        cmp_en = 1;

        applyStimulus(6'b000100, 32'h10, 32'hDEADBEEF, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("st_latency", lat, 32'd3);
        applyStimulus(6'b000000, 32'h10, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ld_latency", lat, 32'd3);
        checkOutput("ld_data", d0, 32'hDEADBEEF);

        applyStimulus(6'b000100, 32'h20, 32'h80FF7F01, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        applyStimulus(6'b001001, 32'h20, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ldsb_20", d0, 32'hFFFFFF80);
        applyStimulus(6'b000001, 32'h21, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ldub_21", d0, 32'h000000FF);
        applyStimulus(6'b001010, 32'h22, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ldsh_22", d0, 32'h00007F01);
        applyStimulus(6'b000010, 32'h20, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("lduh_20", d0, 32'h000080FF);

        applyStimulus(6'b000100, 32'h30, 32'h11223344, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        applyStimulus(6'b000101, 32'h31, 32'h123456AA, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        applyStimulus(6'b000000, 32'h30, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("stb_merge", d0, 32'h11AA3344);
        applyStimulus(6'b000110, 32'h32, 32'hFFFFBEEF, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        applyStimulus(6'b000000, 32'h30, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("sth_merge", d0, 32'h11AABEEF);

        applyStimulus(6'b000111, 32'h40, 32'h01234567, 32'h89ABCDEF, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("std_mfc_count", mcnt, 32'd2);
        applyStimulus(6'b000011, 32'h40, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ldd_mfc_count", mcnt, 32'd2);
        checkOutput("ldd_beat0", d0, 32'h01234567);
        checkOutput("ldd_beat1", d1, 32'h89ABCDEF);

        applyStimulus(6'b000100, 32'h1FC, 32'h5A5AA5A5, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        applyStimulus(6'b000000, 32'h1FC, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ld_top_word", d0, 32'h5A5AA5A5);
        applyStimulus(6'b000011, 32'h40, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);

        applyStimulus(6'b000010, 32'h41, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("lduh_mis_trap", tlat, 32'd1);
        checkOutput("lduh_mis_mfc", mcnt, 32'd0);
        applyStimulus(6'b000000, 32'h42, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ld_mis_trap", tlat, 32'd1);
        applyStimulus(6'b111111, 32'h40, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("illegal_trap", tlat, 32'd1);
        applyStimulus(6'b000000, DEPTH, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ld_range_trap", tlat, 32'd1);
        applyStimulus(6'b000111, 32'h1F8 + 32'h8, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("std_range_trap", tlat, 32'd1);
        applyStimulus(6'b000100, 32'h42, 32'hFFFFFFFF, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("st_mis_mfc", mcnt, 32'd0);
        checkOutput("fault_DataOut_held", DataOut, 32'h89ABCDEF);
        applyStimulus(6'b000000, 32'h40, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("mem_after_faults", d0, 32'h01234567);

        // Abort a store while it is still waiting; memory must keep the old word.
        applyStimulus(6'b000100, 32'h50, 32'hCAFEF00D, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        @(negedge Clk);
        RAM_OpCode = 6'b000100; Address = 32'h50; DataIn = 32'h00000055; RAM_enable = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        RAM_enable = 1'b0;
        @(negedge Clk);
        #2 RESET = 1'b1;
        #1;
        checkOutput("midreset_Busy", {31'd0, Busy}, 32'h0);
        checkOutput("midreset_DataOut", DataOut, 32'h0);
        checkOutput("midreset_MFC", {31'd0, MFC}, 32'h0);
        @(posedge Clk);
        @(negedge Clk);
        RESET = 1'b0;
        repeat (4) @(negedge Clk);
        applyStimulus(6'b000000, 32'h50, 32'h0, 32'h0, 0, lat, tlat, mcnt, d0, d1);
        checkOutput("ld_after_abort", d0, 32'hCAFEF00D);

        applyStimulus(6'b000000, 32'h10, 32'h0, 32'h0, 1, lat, tlat, mcnt, d0, d1);
        checkOutput("busy_pulse_mfc_count", mcnt, 32'd1);
        checkOutput("busy_pulse_data", d0, 32'hDEADBEEF);
        mcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (MFC) mcnt++;
        end
        checkOutput("busy_pulse_no_extra", mcnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
